// File: rtl/bcd_conversion_arbiter.sv
// bcd_conversion_arbiter: round-robin arbiter sharing one binary-to-BCD converter
// among NUM_REQ requesters, with converter timeout and abandoned-request suppression.
module bcd_conversion_arbiter #(
    parameter int NUM_REQ        = 2,
    parameter int INPUT_WIDTH    = 37,
    parameter int DECIMAL_DIGITS = 11,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic                           i_clk,
    input  logic                           i_reset,
    input  logic [NUM_REQ-1:0]             i_req,
    input  logic [NUM_REQ*INPUT_WIDTH-1:0] i_binary,
    output logic [NUM_REQ-1:0]             o_grant,
    output logic [NUM_REQ-1:0]             o_done,
    output logic                           o_error,
    output logic [4*DECIMAL_DIGITS-1:0]    o_bcd,
    output logic                           o_conv_start,
    output logic [INPUT_WIDTH-1:0]         o_conv_binary,
    input  logic                           i_conv_done,
    input  logic [4*DECIMAL_DIGITS-1:0]    i_conv_bcd
);
    localparam int W  = 4 * DECIMAL_DIGITS;
    localparam int IW = NUM_REQ > 1 ? $clog2(NUM_REQ) : 1;
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    typedef enum logic [1:0] {IDLE, START, WAIT, DELIVER} state_t;
    state_t                 state_q, state_d;
    logic [NUM_REQ-1:0]     grant_q, grant_d;
    logic [IW-1:0]          idx_q, idx_d, last_q, last_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic                   err_q, err_d, keep_q, keep_d;
    logic [INPUT_WIDTH-1:0] bin_q, bin_d;
    logic [W-1:0]           bcd_q, bcd_d;
    logic                   found;
    logic [IW-1:0]          win, cand;
    logic                   deliver_ok;
    // search upward from the requester after the last one served, wrapping
    always_comb begin
        found = 1'b0;
        win   = last_q;
        cand  = last_q;
        for (int i = 1; i <= NUM_REQ; i++) begin
            cand = IW'((int'(last_q) + i) % NUM_REQ);
            if (!found && i_req[cand]) begin
                found = 1'b1;
                win   = cand;
            end
        end
    end
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        idx_d   = idx_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        keep_d  = keep_q & |(i_req & grant_q);
        bin_d   = bin_q;
        bcd_d   = bcd_q;
        case (state_q)
            IDLE: begin
                if (found) begin
                    grant_d = NUM_REQ'(1) << win;
                    idx_d   = win;
                    bin_d   = i_binary[win*INPUT_WIDTH +: INPUT_WIDTH];
                    err_d   = 1'b0;
                    keep_d  = 1'b1;
                    state_d = START;
                end
            end
            START: begin
                cnt_d   = '0;
                state_d = WAIT;
            end
            WAIT: begin
                cnt_d = cnt_q + 1'b1;
                if (i_conv_done) begin
                    bcd_d   = i_conv_bcd;
                    state_d = DELIVER;
                end else if (cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
                    err_d   = 1'b1;
                    state_d = DELIVER;
                end
            end
            default: begin
                last_d  = idx_q;
                grant_d = '0;
                state_d = IDLE;
            end
        endcase
    end
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q <= IDLE;
            grant_q <= '0;
            idx_q   <= '0;
            last_q  <= IW'(NUM_REQ - 1);
            cnt_q   <= '0;
            err_q   <= 1'b0;
            keep_q  <= 1'b0;
            bin_q   <= '0;
            bcd_q   <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            idx_q   <= idx_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            keep_q  <= keep_d;
            bin_q   <= bin_d;
            bcd_q   <= bcd_d;
        end
    end
    // a requester that let go at any point after grant gets no done pulse
    assign deliver_ok    = (state_q == DELIVER) && keep_q && |(i_req & grant_q);
    assign o_done        = deliver_ok ? grant_q : '0;
    assign o_error       = deliver_ok & err_q;
    assign o_grant       = grant_q;
    assign o_bcd         = bcd_q;
    assign o_conv_start  = state_q == START;
    assign o_conv_binary = bin_q;
endmodule

// File: tb/tb_bcd_conversion_arbiter.sv
// tb_bcd_conversion_arbiter: directed checks of arbitration, latency, timeout,
// abandoned requests and reset abort, with a behavioural converter per DUT.
module tb_bcd_conversion_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;
    logic [1:0]  c_req, c_grant, c_done, t_req, t_grant, t_done;
    logic [73:0] c_bin, t_bin;
    logic        c_err, c_start, c_cdone, t_err, t_start, t_cdone;
    logic [43:0] c_bcd, c_cbcd, t_bcd, t_cbcd;
    logic [36:0] c_cbin, t_cbin;
    bcd_conversion_arbiter dut (
        .i_clk(clk), .i_reset(rst), .i_req(c_req), .i_binary(c_bin),
        .o_grant(c_grant), .o_done(c_done), .o_error(c_err), .o_bcd(c_bcd),
        .o_conv_start(c_start), .o_conv_binary(c_cbin),
        .i_conv_done(c_cdone), .i_conv_bcd(c_cbcd));
    bcd_conversion_arbiter #(.TIMEOUT_CYCLES(16)) dut_to (
        .i_clk(clk), .i_reset(rst), .i_req(t_req), .i_binary(t_bin),
        .o_grant(t_grant), .o_done(t_done), .o_error(t_err), .o_bcd(t_bcd),
        .o_conv_start(t_start), .o_conv_binary(t_cbin),
        .i_conv_done(t_cdone), .i_conv_bcd(t_cbcd));
    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int overlap = 0;
    int lat[2];
    bit never[2];
    bit stray = 1'b0;
    int cnt[2];
    logic done_v[2];
    logic [43:0] bcd_v[2];
    logic [36:0] pend_b[2];
    assign c_cdone = done_v[0];
    assign c_cbcd  = bcd_v[0];
    assign t_cdone = done_v[1];
    assign t_cbcd  = bcd_v[1];
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) if (!$onehot0(c_grant) || !$onehot0(t_grant)) overlap++;
    function automatic logic [43:0] to_bcd(input logic [36:0] v);
        logic [43:0] r;
        longint x;
        r = '0;
        x = longint'(v);
        for (int d = 0; d < 11; d++) begin
            r[4*d +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction
    // converter model: done goes high lat cycles after the start cycle
    task automatic step(input int m, input logic s, input logic [36:0] b);
        done_v[m] = 1'b0;
        bcd_v[m]  = '0;
        if (rst) begin
            cnt[m] = 0;
        end else if (m == 0 && stray) begin
            done_v[m] = 1'b1;
            bcd_v[m]  = 44'h12345;
        end else if (s && !never[m]) begin
            cnt[m]    = lat[m];
            pend_b[m] = b;
        end else if (cnt[m] > 0) begin
            cnt[m]--;
            if (cnt[m] == 0) begin
                done_v[m] = 1'b1;
                bcd_v[m]  = to_bcd(pend_b[m]);
            end
        end
    endtask
    always @(negedge clk) begin
        step(0, c_start, c_cbin);
        step(1, t_start, t_cbin);
    end
    task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s got %h want %h", n, a, e);
        end
    endtask
    task automatic tick;
        @(posedge clk);
        #1;
    endtask
    task automatic wait_start(input int m, output int t);
        t = -1;
        for (int k = 0; k < 200; k++) begin
            tick();
            if ((m == 0 ? c_start : t_start) === 1'b1) begin
                t = cyc;
                return;
            end
        end
        checks++;
        errors++;
        $display("FAIL start%0d got none want o_conv_start within 200 cycles", m);
    endtask
    task automatic wait_done(input int m, output int t, output logic [1:0] d);
        t = -1;
        d = '0;
        for (int k = 0; k < 200; k++) begin
            tick();
            if ((m == 0 ? c_done : t_done) !== 2'b00) begin
                t = cyc;
                d = m == 0 ? c_done : t_done;
                return;
            end
        end
        checks++;
        errors++;
        $display("FAIL done%0d got none want o_done within 200 cycles", m);
    endtask
    typedef struct {
        int          id;
        logic [36:0] b;
        int          lt;
        logic [43:0] exp_bcd;
    } vec_t;
    vec_t vecs[5];
    initial begin
        int ts, td, nd;
        logic [1:0] d;
        vecs[0] = '{0, 37'd1234567890, 20, 44'h01234567890};
        vecs[1] = '{1, 37'd99, 3, 44'h00000000099};
        vecs[2] = '{0, 37'd0, 1, 44'h0};
        vecs[3] = '{1, 37'd99999999999, 7, 44'h99999999999};
        vecs[4] = '{0, 37'd4096, 2, 44'h00000004096};
        lat = '{3, 5};
        never = '{1'b0, 1'b0};
        c_req = '0; c_bin = '0; t_req = '0; t_bin = '0;
        tick(); tick();
        chk("rst_grant", 64'(c_grant), 0);
        chk("rst_done", 64'(c_done), 0);
        chk("rst_error", 64'(c_err), 0);
        chk("rst_start", 64'(c_start), 0);
        chk("rst_cbin", 64'(c_cbin), 0);
        chk("rst_bcd", 64'(c_bcd), 0);
        rst = 1'b0;
        tick();
        // simultaneous requests held: alternate 0,1,0,1,0,1
        c_bin = {37'd99, 37'd5};
        c_req = 2'b11;
        for (int k = 0; k < 6; k++) begin
            wait_done(0, td, d);
            chk($sformatf("rr_done%0d", k), 64'(d), (k % 2) ? 64'd2 : 64'd1);
            chk($sformatf("rr_bcd%0d", k), 64'(c_bcd), (k % 2) ? 64'h99 : 64'h5);
        end
        c_req = '0;
        tick();
        for (int v = 0; v < 5; v++) begin
            lat[0] = vecs[v].lt;
            c_bin[vecs[v].id*37 +: 37] = vecs[v].b;
            c_req[vecs[v].id] = 1'b1;
            wait_start(0, ts);
            chk($sformatf("v%0d_grant", v), 64'(c_grant), 64'd1 << vecs[v].id);
            chk($sformatf("v%0d_cbin", v), 64'(c_cbin), 64'(vecs[v].b));
            tick();
            chk($sformatf("v%0d_start_pulse", v), 64'(c_start), 0);
            wait_done(0, td, d);
            chk($sformatf("v%0d_done", v), 64'(d), 64'd1 << vecs[v].id);
            chk($sformatf("v%0d_error", v), 64'(c_err), 0);
            chk($sformatf("v%0d_bcd", v), 64'(c_bcd), 64'(vecs[v].exp_bcd));
            chk($sformatf("v%0d_latency", v), 64'(td - ts), 64'(vecs[v].lt + 1));
            c_req = '0;
            tick();
        end
        // req1 abandons during WAIT; operand change after grant is ignored
        lat[0] = 10;
        c_bin = {37'd22, 37'd11};
        c_req = 2'b10;
        wait_start(0, ts);
        chk("drop_grant1", 64'(c_grant), 2);
        tick();
        c_bin = {37'd33, 37'd11};
        c_req = 2'b01;
        nd = 0;
        for (int k = 0; k < 50 && c_start !== 1'b1; k++) begin
            tick();
            if (c_done !== 2'b00) nd++;
        end
        chk("drop_no_done", 64'(nd), 0);
        chk("drop_next_grant", 64'(c_grant), 1);
        chk("drop_bcd_updated", 64'(c_bcd), 64'h22);
        chk("drop_next_cbin", 64'(c_cbin), 11);
        wait_done(0, td, d);
        chk("drop_next_done", 64'(d), 1);
        chk("drop_next_bcd", 64'(c_bcd), 64'h11);
        c_req = '0;
        tick();
        // timeout on the 16-cycle instance, after one good conversion
        t_bin[36:0] = 37'd7;
        t_req = 2'b01;
        wait_start(1, ts);
        wait_done(1, td, d);
        chk("to_pre_bcd", 64'(t_bcd), 7);
        chk("to_pre_error", 64'(t_err), 0);
        t_req = '0;
        tick();
        never[1] = 1'b1;
        t_bin[36:0] = 37'd8;
        t_req = 2'b01;
        wait_start(1, ts);
        wait_done(1, td, d);
        chk("to_latency", 64'(td - ts), 17);
        chk("to_done", 64'(d), 1);
        chk("to_error", 64'(t_err), 1);
        chk("to_bcd_kept", 64'(t_bcd), 7);
        t_req = '0;
        tick();
        chk("to_error_pulse", 64'(t_err), 0);
        // reset in the middle of WAIT, then a stray converter done
        lat[0] = 10;
        c_bin[36:0] = 37'd44;
        c_req = 2'b01;
        wait_start(0, ts);
        tick(); tick(); tick();
        #2 rst = 1'b1;
        #1;
        chk("abort_grant", 64'(c_grant), 0);
        chk("abort_start", 64'(c_start), 0);
        chk("abort_cbin", 64'(c_cbin), 0);
        chk("abort_bcd", 64'(c_bcd), 0);
        c_req = '0;
        tick(); tick();
        rst = 1'b0;
        stray = 1'b1;
        tick();
        stray = 1'b0;
        nd = 0;
        for (int k = 0; k < 20; k++) begin
            tick();
            if (c_done !== 2'b00 || c_grant !== 2'b00 || c_err !== 1'b0 || c_start !== 1'b0) nd++;
        end
        chk("stray_ignored", 64'(nd), 0);
        chk("stray_bcd", 64'(c_bcd), 0);
        chk("grant_onehot", 64'(overlap), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
